vivo_pop_scheduler: RTL

- Shares the single variable-width pop port of one vivo_fifo among N_REQ consumers.
- Each consumer posts a request for 1..OUT_ELEMS_MAX elements. The scheduler grants round-robin, drives out_req_elems, waits for the FIFO's registered out_valid, then routes data to the winner.
- A wait timeout abandons a request the FIFO cannot satisfy, so one consumer waiting on a large request cannot block the others.

---
 rtl/vivo_pkg.sv | 20 ++
 rtl/vivo_pop_scheduler_if.sv | 37 +++
 rtl/vivo_rr_arbiter.sv | 26 ++
 rtl/vivo_pop_scheduler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/vivo_pkg.sv
// Shared types and width helpers for the vivo pop/push scheduling blocks.
package vivo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ABANDON = 2'd2,
        DELIVER = 2'd3
    } sched_state_e;

    // Element-count width: must represent 0..max_elems inclusive.
    function automatic int calc_outw(input int max_elems);
        return $clog2(max_elems + 1);
    endfunction

    function automatic int calc_req_w(input int n_req);
        return (n_req <= 1) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/vivo_pop_scheduler_if.sv
// Consumer-side and FIFO-side pop bus of the scheduler; master is the scheduler.
interface vivo_pop_scheduler_if #(
    parameter int ELEM_WIDTH    = 8,
    parameter int OUT_ELEMS_MAX = 4,
    parameter int N_REQ         = 4
);
    import vivo_pkg::*;

    localparam int OUTW = calc_outw(OUT_ELEMS_MAX);

    logic [N_REQ-1:0]                           req_valid;
    logic [N_REQ-1:0][OUTW-1:0]                 req_elems;
    logic [N_REQ-1:0]                           rsp_valid;
    logic [N_REQ-1:0]                           rsp_ready;
    logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0]   rsp_data;
    logic [OUTW-1:0]                            rsp_num_elems;
    logic                                       fifo_out_valid;
    logic                                       fifo_out_ready;
    logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0]   fifo_out_data;
    logic [OUTW-1:0]                            fifo_out_num_elems;
    logic [OUTW-1:0]                            fifo_out_req_elems;

    modport master (
        input  req_valid, req_elems, rsp_ready,
        input  fifo_out_valid, fifo_out_data, fifo_out_num_elems,
        output rsp_valid, rsp_data, rsp_num_elems,
        output fifo_out_ready, fifo_out_req_elems
    );

    modport slave (
        output req_valid, req_elems, rsp_ready,
        output fifo_out_valid, fifo_out_data, fifo_out_num_elems,
        input  rsp_valid, rsp_data, rsp_num_elems,
        input  fifo_out_ready, fifo_out_req_elems
    );

endinterface

// File: rtl/vivo_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr, wrapping.
module vivo_rr_arbiter
    import vivo_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int REQ_W = calc_req_w(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [REQ_W-1:0] rr_ptr,
    output logic [REQ_W-1:0] grant,
    output logic             any_grant
);

    // Lowest eligible index is the fallback; a masked hit at/after rr_ptr overrides it.
    always_comb begin
        grant     = '0;
        any_grant = |eligible;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) grant = REQ_W'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i] && (i >= int'(rr_ptr))) grant = REQ_W'(i);
        end
    end

endmodule

// File: rtl/vivo_pop_scheduler.sv
// Shares one variable-width FIFO pop port among N_REQ consumers, round-robin with wait timeout.
module vivo_pop_scheduler
    import vivo_pkg::*;
#(
    parameter int ELEM_WIDTH    = 8,
    parameter int OUT_ELEMS_MAX = 4,
    parameter int N_REQ         = 4,
    parameter int MAX_WAIT      = 16,
    localparam int REQ_W = calc_req_w(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vivo_pop_scheduler_if.master bus,
    output logic [REQ_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 timeout_pulse,
    output logic                 req_err
);

    localparam int OUTW = calc_outw(OUT_ELEMS_MAX);
    localparam int WCW  = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    sched_state_e     state;
    logic [REQ_W-1:0] rr_ptr;
    logic [OUTW-1:0]  held_elems;
    logic [WCW-1:0]   wait_cnt;
    logic             abandon_by_timeout;

    logic [N_REQ-1:0] eligible;
    logic             illegal_req;
    logic [REQ_W-1:0] arb_grant;
    logic             any_grant;
    logic [REQ_W-1:0] next_ptr;
    logic             handshake;

    always_comb begin
        eligible    = '0;
        illegal_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = bus.req_valid[i] && (bus.req_elems[i] != '0) &&
                          (bus.req_elems[i] <= OUTW'(OUT_ELEMS_MAX));
            if (bus.req_valid[i] && !eligible[i]) illegal_req = 1'b1;
        end
    end

    vivo_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .any_grant (any_grant)
    );

    assign next_ptr  = (grant_id == REQ_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign handshake = (state == DELIVER) && bus.fifo_out_valid && bus.rsp_ready[grant_id];
    assign busy      = (state != IDLE);

    // A valid seen in WAIT or ABANDON always wins, so a pop the FIFO already committed is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            grant_id           <= '0;
            held_elems         <= '0;
            wait_cnt           <= '0;
            abandon_by_timeout <= 1'b0;
            timeout_pulse      <= 1'b0;
            req_err            <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            if (illegal_req) req_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        grant_id   <= arb_grant;
                        held_elems <= bus.req_elems[arb_grant];
                        wait_cnt   <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.fifo_out_valid) begin
                        state <= DELIVER;
                    end else if (!bus.req_valid[grant_id]) begin
                        abandon_by_timeout <= 1'b0;
                        state              <= ABANDON;
                    end else if ((MAX_WAIT != 0) && (wait_cnt == WAIT_LAST)) begin
                        abandon_by_timeout <= 1'b1;
                        state              <= ABANDON;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ABANDON: begin
                    if (bus.fifo_out_valid) begin
                        state <= DELIVER;
                    end else begin
                        timeout_pulse <= abandon_by_timeout;
                        rr_ptr        <= next_ptr;
                        state         <= IDLE;
                    end
                end
                DELIVER: begin
                    if (handshake) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request size is withdrawn in ABANDON so the FIFO cannot raise a fresh valid.
    always_comb begin
        bus.fifo_out_req_elems = '0;
        bus.rsp_valid          = '0;
        bus.rsp_data           = '0;
        bus.rsp_num_elems      = '0;
        bus.fifo_out_ready     = 1'b0;
        if ((state == WAIT) || (state == DELIVER)) bus.fifo_out_req_elems = held_elems;
        if (state == DELIVER) begin
            bus.rsp_valid[grant_id] = bus.fifo_out_valid;
            bus.rsp_data            = bus.fifo_out_data;
            bus.rsp_num_elems       = bus.fifo_out_num_elems;
            bus.fifo_out_ready      = bus.rsp_ready[grant_id];
        end
    end

endmodule
